// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss/fill controller: issues line loads, tracks outstanding tags, writes fills.
// Optional next-line prefetch is enabled by defining ICACHE_PREFETCH_EN.
module icache_fill_ctrl #(
  parameter int NUM_MSHR       = 4,
  parameter int PREFETCH_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [63:0] fetch_pc,
  input  logic        cache_hit,
  input  logic [3:0]  Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_tag,
  output logic [1:0]  proc2Imem_command,
  output logic [63:0] proc2Imem_addr,
  output logic        wr_en,
  output logic [63:0] wr_data,
  output logic [63:0] wr_pc_reg,
  output logic        fetch_stall,
  output logic        mshr_full
);

  localparam int IW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  if (NUM_MSHR < 1 || NUM_MSHR > 15 || PREFETCH_DEPTH < 0) begin : g_param_check
    $error("icache_fill_ctrl: NUM_MSHR must be 1..15 and PREFETCH_DEPTH >= 0");
  end

  logic [NUM_MSHR-1:0] mshr_valid_r;
  logic [3:0]          mshr_tag_r  [NUM_MSHR];
  logic [60:0]         mshr_line_r [NUM_MSHR];

  logic                wr_en_r;
  logic [63:0]         wr_data_r;
  logic [63:0]         wr_pc_r;

  logic [60:0]         demand_line_s;
  logic                demand_pend_s;
  logic                mshr_full_s;
  logic                free_found_s;
  logic [IW-1:0]       free_idx_s;
  logic                fill_hit_s;
  logic [IW-1:0]       fill_idx_s;
  logic                req_load_s;
  logic                req_demand_s;
  logic [60:0]         req_line_s;
  logic                accept_s;
  logic                unused_s;

  assign demand_line_s = fetch_pc[63:3];
  assign mshr_full_s   = &mshr_valid_r;
  assign unused_s      = ^fetch_pc[2:0] ^ free_found_s;

`ifdef ICACHE_PREFETCH_EN
  localparam int PF_CW = (PREFETCH_DEPTH > 0) ? $clog2(PREFETCH_DEPTH + 1) : 1;

  logic [60:0]      pf_line_r;
  logic [PF_CW-1:0] pf_cnt_r;
  logic             pf_pend_s;
  logic             pf_skip_s;

  // Pending lookup for the prefetch candidate line.
  always_comb begin
    pf_pend_s = 1'b0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (mshr_valid_r[i] && (mshr_line_r[i] == pf_line_r)) begin
        pf_pend_s = 1'b1;
      end else begin
        pf_pend_s = pf_pend_s;
      end
    end
  end
`endif

  // Pending lookup for the demand fetch line.
  always_comb begin
    demand_pend_s = 1'b0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (mshr_valid_r[i] && (mshr_line_r[i] == demand_line_s)) begin
        demand_pend_s = 1'b1;
      end else begin
        demand_pend_s = demand_pend_s;
      end
    end
  end

  // Lowest-index free entry (registered state only) and lowest matching fill entry.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    fill_hit_s   = 1'b0;
    fill_idx_s   = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (!mshr_valid_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IW'(i);
      end else begin
        free_found_s = free_found_s;
      end
      if (mshr_valid_r[i] && (Imem2proc_tag != 4'd0) && (mshr_tag_r[i] == Imem2proc_tag)) begin
        fill_hit_s = 1'b1;
        fill_idx_s = IW'(i);
      end else begin
        fill_hit_s = fill_hit_s;
      end
    end
  end

  // Request select: demand first, then the prefetch candidate.
  always_comb begin
    req_load_s   = 1'b0;
    req_demand_s = 1'b0;
    req_line_s   = '0;
`ifdef ICACHE_PREFETCH_EN
    pf_skip_s    = 1'b0;
`endif
    if (fetch_valid && !cache_hit && !demand_pend_s && !mshr_full_s) begin
      req_load_s   = 1'b1;
      req_demand_s = 1'b1;
      req_line_s   = demand_line_s;
    end else begin
`ifdef ICACHE_PREFETCH_EN
      if ((pf_cnt_r != '0) && !mshr_full_s) begin
        if (pf_pend_s) begin
          pf_skip_s = 1'b1;
        end else begin
          req_load_s = 1'b1;
          req_line_s = pf_line_r;
        end
      end else begin
        pf_skip_s = 1'b0;
      end
`else
      req_load_s = 1'b0;
`endif
    end
  end

  // Bus outputs are held idle while reset is asserted.
  always_comb begin
    proc2Imem_command = BUS_NONE;
    proc2Imem_addr    = 64'd0;
    if (reset && req_load_s) begin
      proc2Imem_command = BUS_LOAD;
      proc2Imem_addr    = {req_line_s, 3'b000};
    end else begin
      proc2Imem_command = BUS_NONE;
    end
  end

  assign accept_s    = reset && req_load_s && (Imem2proc_response != 4'd0);
  assign fetch_stall = fetch_valid && !cache_hit;
  assign mshr_full   = mshr_full_s;

  // MSHR table: fill clears its entry, accept claims a slot free before this edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mshr_valid_r <= '0;
      for (int i = 0; i < NUM_MSHR; i++) begin
        mshr_tag_r[i]  <= 4'd0;
        mshr_line_r[i] <= 61'd0;
      end
    end else begin
      if (fill_hit_s) begin
        mshr_valid_r[fill_idx_s] <= 1'b0;
      end
      if (accept_s) begin
        mshr_valid_r[free_idx_s] <= 1'b1;
        mshr_tag_r[free_idx_s]   <= Imem2proc_response;
        mshr_line_r[free_idx_s]  <= req_line_s;
      end
    end
  end

  // Cache array write port: one-cycle strobe, data and address hold between fills.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en_r   <= 1'b0;
      wr_data_r <= 64'd0;
      wr_pc_r   <= 64'd0;
    end else if (fill_hit_s) begin
      wr_en_r   <= 1'b1;
      wr_data_r <= Imem2proc_data;
      wr_pc_r   <= {mshr_line_r[fill_idx_s], 3'b000};
    end else begin
      wr_en_r   <= 1'b0;
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_data   = wr_data_r;
  assign wr_pc_reg = wr_pc_r;

`ifdef ICACHE_PREFETCH_EN
  // Prefetch pointer: rearmed by each demand accept, advanced by prefetch accept or skip.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pf_line_r <= 61'd0;
      pf_cnt_r  <= '0;
    end else if (accept_s && req_demand_s) begin
      pf_line_r <= req_line_s + 61'd1;
      pf_cnt_r  <= PF_CW'(PREFETCH_DEPTH);
    end else if (accept_s || pf_skip_s) begin
      pf_line_r <= pf_line_r + 61'd1;
      pf_cnt_r  <= pf_cnt_r - PF_CW'(1);
    end else begin
      pf_line_r <= pf_line_r;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: vector table for miss/fill/full behaviour plus corner sequences.
module tb_icache_fill_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [63:0] fetch_pc = 64'd0;
  logic        cache_hit = 1'b0;
  logic [3:0]  Imem2proc_response = 4'd0;
  logic [63:0] Imem2proc_data = 64'd0;
  logic [3:0]  Imem2proc_tag = 4'd0;
  logic [1:0]  proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  logic        wr_en;
  logic [63:0] wr_data;
  logic [63:0] wr_pc_reg;
  logic        fetch_stall;
  logic        mshr_full;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D2 = 64'h0BAD_CAFE_8899_AABB;
  localparam logic [63:0] D3 = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] D4 = 64'hFFFF_0000_FFFF_0000;

  typedef struct packed {
    logic        fv;
    logic        hit;
    logic [63:0] pc;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] data;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic        stall;
    logic        full;
    logic        wen;
    logic [63:0] wpc;
    logic [63:0] wdata;
  } vec_t;

  vec_t vt [24];

  always #5 clock = ~clock;

  icache_fill_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .cache_hit          (cache_hit),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .wr_en              (wr_en),
    .wr_data            (wr_data),
    .wr_pc_reg          (wr_pc_reg),
    .fetch_stall        (fetch_stall),
    .mshr_full          (mshr_full)
  );

  function automatic vec_t mk(input logic fv, input logic hit, input logic [63:0] pc,
                              input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] data,
                              input logic [1:0] cmd, input logic [63:0] addr, input logic stall,
                              input logic full, input logic wen, input logic [63:0] wpc,
                              input logic [63:0] wdata);
    vec_t v;
    v = '{fv, hit, pc, resp, tag, data, cmd, addr, stall, full, wen, wpc, wdata};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic fv, input logic hit, input logic [63:0] pc,
                       input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] data);
    @(negedge clock);
    fetch_valid        = fv;
    cache_hit          = hit;
    fetch_pc           = pc;
    Imem2proc_response = resp;
    Imem2proc_tag      = tag;
    Imem2proc_data     = data;
    #1;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clock);
    reset              = 1'b0;
    fetch_valid        = 1'b1;
    cache_hit          = 1'b0;
    fetch_pc           = 64'h1234;
    Imem2proc_response = 4'd3;
    Imem2proc_tag      = 4'd0;
    #1;
    chk({nm, " rst cmd"},   64'(proc2Imem_command), 64'd0);
    chk({nm, " rst addr"},  proc2Imem_addr, 64'd0);
    chk({nm, " rst wr_en"}, 64'(wr_en), 64'd0);
    chk({nm, " rst wdata"}, wr_data, 64'd0);
    chk({nm, " rst wpc"},   wr_pc_reg, 64'd0);
    chk({nm, " rst full"},  64'(mshr_full), 64'd0);
    @(negedge clock);
    reset              = 1'b1;
    fetch_valid        = 1'b0;
    Imem2proc_response = 4'd0;
  endtask

  initial begin
    vt[0]  = mk(1, 0, 64'h1004, 4'd5, 4'd0, 64'd0, 2'd1, 64'h1000, 1, 0, 0, 64'h0,    64'h0);
    vt[1]  = mk(1, 0, 64'h1004, 4'd0, 4'd0, 64'd0, 2'd0, 64'h0,    1, 0, 0, 64'h0,    64'h0);
    vt[2]  = mk(1, 0, 64'h1004, 4'd0, 4'd0, 64'd0, 2'd0, 64'h0,    1, 0, 0, 64'h0,    64'h0);
    vt[3]  = mk(1, 0, 64'h1004, 4'd0, 4'd0, 64'd0, 2'd0, 64'h0,    1, 0, 0, 64'h0,    64'h0);
    vt[4]  = mk(1, 0, 64'h1004, 4'd0, 4'd5, D1,    2'd0, 64'h0,    1, 0, 0, 64'h0,    64'h0);
    vt[5]  = mk(1, 1, 64'h1004, 4'd0, 4'd0, 64'd0, 2'd0, 64'h0,    0, 0, 1, 64'h1000, D1);
    vt[6]  = mk(1, 1, 64'h1004, 4'd0, 4'd0, 64'd0, 2'd0, 64'h0,    0, 0, 0, 64'h1000, D1);
    vt[7]  = mk(1, 0, 64'h1000, 4'd0, 4'd0, 64'd0, 2'd1, 64'h1000, 1, 0, 0, 64'h1000, D1);
    vt[8]  = mk(1, 0, 64'h1000, 4'd0, 4'd0, 64'd0, 2'd1, 64'h1000, 1, 0, 0, 64'h1000, D1);
    vt[9]  = mk(1, 0, 64'h1000, 4'd0, 4'd0, 64'd0, 2'd1, 64'h1000, 1, 0, 0, 64'h1000, D1);
    vt[10] = mk(1, 0, 64'h1000, 4'd7, 4'd0, 64'd0, 2'd1, 64'h1000, 1, 0, 0, 64'h1000, D1);
    vt[11] = mk(1, 0, 64'h1000, 4'd0, 4'd7, D2,    2'd0, 64'h0,    1, 0, 0, 64'h1000, D1);
    vt[12] = mk(0, 0, 64'h1000, 4'd0, 4'd0, 64'd0, 2'd0, 64'h0,    0, 0, 1, 64'h1000, D2);
    vt[13] = mk(1, 0, 64'h1000, 4'd0, 4'd0, 64'd0, 2'd1, 64'h1000, 1, 0, 0, 64'h1000, D2);
    vt[14] = mk(1, 0, 64'h3000, 4'd1, 4'd0, 64'd0, 2'd1, 64'h3000, 1, 0, 0, 64'h1000, D2);
    vt[15] = mk(1, 0, 64'h3008, 4'd2, 4'd0, 64'd0, 2'd1, 64'h3008, 1, 0, 0, 64'h1000, D2);
    vt[16] = mk(1, 0, 64'h3010, 4'd3, 4'd0, 64'd0, 2'd1, 64'h3010, 1, 0, 0, 64'h1000, D2);
    vt[17] = mk(1, 0, 64'h3018, 4'd4, 4'd0, 64'd0, 2'd1, 64'h3018, 1, 0, 0, 64'h1000, D2);
    vt[18] = mk(1, 0, 64'h3020, 4'd9, 4'd0, 64'd0, 2'd0, 64'h0,    1, 1, 0, 64'h1000, D2);
    vt[19] = mk(1, 0, 64'h3020, 4'd9, 4'd2, D3,    2'd0, 64'h0,    1, 1, 0, 64'h1000, D2);
    vt[20] = mk(1, 0, 64'h3020, 4'd9, 4'd0, 64'd0, 2'd1, 64'h3020, 1, 0, 1, 64'h3008, D3);
    vt[21] = mk(1, 0, 64'h3020, 4'd0, 4'd0, 64'd0, 2'd0, 64'h0,    1, 1, 0, 64'h3008, D3);
    vt[22] = mk(0, 0, 64'h3020, 4'd0, 4'd11, D4,   2'd0, 64'h0,    0, 1, 0, 64'h3008, D3);
    vt[23] = mk(0, 0, 64'h3020, 4'd0, 4'd0, 64'd0, 2'd0, 64'h0,    0, 1, 0, 64'h3008, D3);

`ifndef ICACHE_PREFETCH_EN
    do_reset("tbl");
    for (int i = 0; i < 24; i++) begin
      drive(vt[i].fv, vt[i].hit, vt[i].pc, vt[i].resp, vt[i].tag, vt[i].data);
      chk($sformatf("v%0d cmd", i),   64'(proc2Imem_command), 64'(vt[i].cmd));
      chk($sformatf("v%0d addr", i),  proc2Imem_addr, vt[i].addr);
      chk($sformatf("v%0d stall", i), 64'(fetch_stall), 64'(vt[i].stall));
      chk($sformatf("v%0d full", i),  64'(mshr_full), 64'(vt[i].full));
      chk($sformatf("v%0d wr_en", i), 64'(wr_en), 64'(vt[i].wen));
      chk($sformatf("v%0d wpc", i),   wr_pc_reg, vt[i].wpc);
      chk($sformatf("v%0d wdata", i), wr_data, vt[i].wdata);
    end
`endif

    // Reset with three fills outstanding; a stale tag afterwards must not write.
    do_reset("mid0");
    drive(1, 0, 64'h5000, 4'd1, 4'd0, 64'd0);
    drive(1, 0, 64'h5008, 4'd2, 4'd0, 64'd0);
    drive(1, 0, 64'h5010, 4'd3, 4'd0, 64'd0);
    do_reset("mid1");
    drive(0, 0, 64'h0, 4'd0, 4'd2, D1);
    chk("mid cmd",  64'(proc2Imem_command), 64'd0);
    chk("mid full", 64'(mshr_full), 64'd0);
    drive(1, 0, 64'h5008, 4'd0, 4'd0, 64'd0);
    chk("mid wr_en", 64'(wr_en), 64'd0);
    chk("mid wdata", wr_data, 64'd0);
    chk("mid reissue cmd",  64'(proc2Imem_command), 64'd1);
    chk("mid reissue addr", proc2Imem_addr, 64'h5008);

    // Fill and accept carrying the same tag in one cycle.
    do_reset("same");
    drive(1, 0, 64'h4000, 4'd6, 4'd0, 64'd0);
    drive(1, 0, 64'h4008, 4'd6, 4'd6, D2);
    chk("same cmd",  64'(proc2Imem_command), 64'd1);
    chk("same addr", proc2Imem_addr, 64'h4008);
    drive(0, 0, 64'h0, 4'd0, 4'd6, D3);
    chk("same wr1 en",  64'(wr_en), 64'd1);
    chk("same wr1 pc",  wr_pc_reg, 64'h4000);
    chk("same wr1 dat", wr_data, D2);
    drive(0, 0, 64'h0, 4'd0, 4'd0, 64'd0);
    chk("same wr2 en",  64'(wr_en), 64'd1);
    chk("same wr2 pc",  wr_pc_reg, 64'h4008);
    chk("same wr2 dat", wr_data, D3);

`ifdef ICACHE_PREFETCH_EN
    // Two next-line prefetches after a demand accept.
    do_reset("pf0");
    drive(1, 0, 64'h2000, 4'd1, 4'd0, 64'd0);
    chk("pf0 d addr", proc2Imem_addr, 64'h2000);
    drive(0, 0, 64'h0, 4'd2, 4'd0, 64'd0);
    chk("pf0 p1 cmd",  64'(proc2Imem_command), 64'd1);
    chk("pf0 p1 addr", proc2Imem_addr, 64'h2008);
    drive(0, 0, 64'h0, 4'd3, 4'd0, 64'd0);
    chk("pf0 p2 addr", proc2Imem_addr, 64'h2010);
    drive(0, 0, 64'h0, 4'd4, 4'd0, 64'd0);
    chk("pf0 end cmd", 64'(proc2Imem_command), 64'd0);

    // Already-pending prefetch candidate is skipped.
    do_reset("pf1");
    drive(1, 0, 64'h2008, 4'd1, 4'd0, 64'd0);
    drive(1, 0, 64'h2000, 4'd2, 4'd0, 64'd0);
    chk("pf1 d addr", proc2Imem_addr, 64'h2000);
    drive(0, 0, 64'h0, 4'd5, 4'd0, 64'd0);
    chk("pf1 skip cmd", 64'(proc2Imem_command), 64'd0);
    drive(0, 0, 64'h0, 4'd5, 4'd0, 64'd0);
    chk("pf1 p cmd",  64'(proc2Imem_command), 64'd1);
    chk("pf1 p addr", proc2Imem_addr, 64'h2010);
    drive(0, 0, 64'h0, 4'd6, 4'd0, 64'd0);
    chk("pf1 end cmd", 64'(proc2Imem_command), 64'd0);
`endif

    // Demand miss at the top line of the address space.
    do_reset("wrap");
    drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 4'd1, 4'd0, 64'd0);
    chk("wrap d cmd",  64'(proc2Imem_command), 64'd1);
    chk("wrap d addr", proc2Imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    drive(0, 0, 64'h0, 4'd2, 4'd0, 64'd0);
`ifdef ICACHE_PREFETCH_EN
    chk("wrap p1 cmd",  64'(proc2Imem_command), 64'd1);
    chk("wrap p1 addr", proc2Imem_addr, 64'h0);
    drive(0, 0, 64'h0, 4'd3, 4'd0, 64'd0);
    chk("wrap p2 cmd",  64'(proc2Imem_command), 64'd1);
    chk("wrap p2 addr", proc2Imem_addr, 64'h8);
`else
    chk("wrap p1 cmd", 64'(proc2Imem_command), 64'd0);
    drive(0, 0, 64'h0, 4'd3, 4'd0, 64'd0);
    chk("wrap p2 cmd", 64'(proc2Imem_command), 64'd0);
`endif
    drive(0, 0, 64'h0, 4'd4, 4'd0, 64'd0);
    chk("wrap end cmd", 64'(proc2Imem_command), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
